// File: rtl/destuff_data.sv
// Receive-side destuffer: regenerates the data/stuff slot pattern from pm/cm latched at sof,
// forwards data-slot words, and flags ds/sof/config errors. All outputs are registered.
module destuff_data #(
    parameter int unsigned MPT_W  = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sof,
    input  logic [MPT_W-1:0]  pm,
    input  logic [MPT_W-1:0]  cm,
    input  logic              valid_in,
    input  logic              ds_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              first_out,
    output logic              last_out,
    output logic              frame_done,
    output logic              ds_err,
    output logic              sof_err,
    output logic              cfg_err
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [MPT_W-1:0] One = MPT_W'(1);

    state_e             state_q, state_d;
    logic [MPT_W-1:0]   pm_q, pm_d, cm_q, cm_d, acc_q, acc_d;
    logic [MPT_W-1:0]   slot_cnt_q, slot_cnt_d, data_cnt_q, data_cnt_d;
    logic [DATA_W-1:0]  data_out_q, data_out_d;
    logic               data_valid_q, data_valid_d, first_q, first_d, last_q, last_d;
    logic               frame_done_q, frame_done_d, ds_err_q, ds_err_d;
    logic               sof_err_q, sof_err_d, cfg_err_q, cfg_err_d;

    logic [MPT_W:0]     sum;
    logic [MPT_W-1:0]   acc_sub;
    logic               is_data;
    logic               cfg_ok;

    // acc < pm_q always holds, so the extra bit of sum never overflows.
    assign sum     = {1'b0, acc_q} + {1'b0, cm_q};
    assign is_data = (sum >= {1'b0, pm_q});
    assign acc_sub = MPT_W'(sum - {1'b0, pm_q});
    assign cfg_ok  = (pm != '0) && (cm <= pm);

    always_comb begin
        state_d      = state_q;
        pm_d         = pm_q;
        cm_d         = cm_q;
        acc_d        = acc_q;
        slot_cnt_d   = slot_cnt_q;
        data_cnt_d   = data_cnt_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        first_d      = 1'b0;
        last_d       = 1'b0;
        frame_done_d = 1'b0;
        ds_err_d     = 1'b0;
        sof_err_d    = 1'b0;
        cfg_err_d    = 1'b0;

        if (sof) begin
            // sof wins over any slot presented in the same cycle.
            sof_err_d = (state_q == StRun);
            if (cfg_ok) begin
                pm_d       = pm;
                cm_d       = cm;
                acc_d      = '0;
                slot_cnt_d = '0;
                data_cnt_d = '0;
                state_d    = StRun;
            end else begin
                cfg_err_d = 1'b1;
                state_d   = StIdle;
            end
        end else if (state_q == StRun && valid_in) begin
            acc_d    = is_data ? acc_sub : sum[MPT_W-1:0];
            ds_err_d = (ds_in != is_data);
            if (is_data) begin
                data_out_d   = data_in;
                data_valid_d = 1'b1;
                first_d      = (data_cnt_q == '0);
                last_d       = (data_cnt_q + One == cm_q);
                data_cnt_d   = data_cnt_q + One;
            end
            slot_cnt_d = slot_cnt_q + One;
            if (slot_cnt_q + One == pm_q) begin
                frame_done_d = 1'b1;
                state_d      = StIdle;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pm_q         <= '0;
            cm_q         <= '0;
            acc_q        <= '0;
            slot_cnt_q   <= '0;
            data_cnt_q   <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            frame_done_q <= 1'b0;
            ds_err_q     <= 1'b0;
            sof_err_q    <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pm_q         <= pm_d;
            cm_q         <= cm_d;
            acc_q        <= acc_d;
            slot_cnt_q   <= slot_cnt_d;
            data_cnt_q   <= data_cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            first_q      <= first_d;
            last_q       <= last_d;
            frame_done_q <= frame_done_d;
            ds_err_q     <= ds_err_d;
            sof_err_q    <= sof_err_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign first_out  = first_q;
    assign last_out   = last_q;
    assign frame_done = frame_done_q;
    assign ds_err     = ds_err_q;
    assign sof_err    = sof_err_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: doc/destuff_data.md
Name: destuff_data

Overview:
- Receive-side counterpart of the stuff/data slot generator.
- Per frame, latches frame length pm and data count cm at sof, then regenerates the same data/stuff (ds) slot pattern locally over pm valid slots.
- Forwards only data-slot words and drops stuff slots.
- Checks the link-supplied ds flag against the local pattern and flags framing errors. Sits after the link deframer, before the payload FIFO.

Parameters:
- MPT_W, 8, width of pm, cm and internal slot/data counters.
- DATA_W, 8, width of data_in/data_out.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sof  input  1  start of frame; pm/cm valid this cycle; this is not a slot.
- pm  input  MPT_W  slots per frame, sampled on sof.
- cm  input  MPT_W  data slots per frame, sampled on sof.
- valid_in  input  1  one slot present this cycle.
- ds_in  input  1  link's data(1)/stuff(0) flag for the slot.
- data_in  input  DATA_W  slot payload.
- data_out  output  DATA_W  extracted data word.
- data_valid  output  1  data_out valid.
- first_out  output  1  with data_valid: first data word of frame.
- last_out  output  1  with data_valid: cm-th data word of frame.
- frame_done  output  1  one-cycle pulse after pm-th slot consumed.
- ds_err  output  1  pulse: ds_in differs from local pattern on a slot.
- sof_err  output  1  pulse: sof arrived while frame in progress.
- cfg_err  output  1  pulse: sof with pm==0 or cm>pm.

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; data_out=0; accumulators and counters 0.
- All outputs are registered. Latency is 1 cycle from the slot's valid_in cycle to data_valid/flags. Pulses last one cycle. With no valid_in, data_valid, first_out, last_out and ds_err are 0.
- States: IDLE, RUN.
- IDLE:
  - sof with pm!=0 and cm<=pm → latch pm_r/cm_r; acc=0, slot_cnt=0, data_cnt=0; go to RUN.
  - sof with bad config → cfg_err=1; stay in IDLE.
  - valid_in without sof → ignored; no outputs.
- RUN, per slot (valid_in=1):
  - sum = acc + cm_r, computed at MPT_W+1 bits. Cannot overflow, because acc<pm_r.
  - Data slot when sum>=pm_r: acc<=sum-pm_r. Otherwise acc<=sum.
  - Equivalently, slot i (1-based) is data iff floor(i*cm/pm) > floor((i-1)*cm/pm).
  - Data slot: data_out<=data_in; data_valid=1; data_cnt++.
  - first_out=1 when data_cnt was 0.
  - last_out=1 when data_cnt+1==cm_r.
  - Stuff slot: data_out holds its value; data_valid=0.
  - ds_err=1 when ds_in != local flag. Extraction always follows the local pattern, never ds_in.
  - slot_cnt++. On the slot where slot_cnt+1==pm_r: frame_done=1 next cycle; return to IDLE.
  - valid_in=0: all state frozen; no outputs.
- sof in RUN, simultaneous with or without valid_in:
  - The sof takes priority; the slot on that cycle is discarded.
  - sof_err=1. The current frame is abandoned with no frame_done and no last_out.
  - New pm/cm are latched and checked as in IDLE. On a config fail, cfg_err=1 as well and the block goes to IDLE.
- cm==0: no data_valid for the whole frame; frame_done still pulses after pm slots.
- cm==pm: every slot is data; first_out on slot 1, last_out on slot pm.
- pm==1, cm==1: first_out and last_out both 1 on the single word, and frame_done on the next cycle.
- Back-to-back: sof is accepted in the cycle after the last slot, since the block is already in IDLE. frame_done for the old frame and the new frame's latch can coincide.
- rst_n asserted mid-frame: immediate return to IDLE; all outputs cleared.

Test Plan:
1. sof pm=8 cm=3, 8 consecutive valid slots with data 0x10..0x17 and correct ds_in → data_valid on slots 3,6,8 with data 0x12 (first_out), 0x15, 0x17 (last_out); frame_done one cycle after slot 8; no errors.
2. Same frame with valid_in gaps of 1–3 cycles and ds_in wrong on slot 4 → identical data sequence; ds_err single pulse 1 cycle after slot 4.
3. pm=4 cm=4 then immediately pm=5 cm=0 → 4 data words, then 5 stuff slots with no data_valid; two frame_done pulses.
4. pm=8 cm=3, sof again after 5 slots (pm=2 cm=1) → sof_err pulse; old frame gives no frame_done or last_out; new frame outputs slot-2 word with first_out and last_out.
5. sof pm=3 cm=4, then sof pm=0 cm=0 → cfg_err each time; block stays in IDLE; following valid slots produce nothing.
6. rst_n low for 1 cycle at slot 4 of a pm=8 cm=3 frame → all outputs 0 immediately; later slots ignored until the next sof.
